// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg
//   Shared definitions for the interrupt controller slice:
//   - ctrlState_e : arbitration FSM states (encoding is visible in STATUS[9:8])
//   - ADDR_*      : register-select codes presented on reg_addr
//   - STATUS_STATE_LSB : bit position of the state field inside STATUS
package int_ctrl_pkg;

  // The numeric encoding is software-visible through STATUS, so it is fixed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    INSVC = 2'd2
  } ctrlState_e;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_MODE    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int STATUS_STATE_LSB = 8;

endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc
//   Lowest-index-wins priority encoder over NUM_INT request lines.
//   Ports:
//     req_i   [NUM_INT-1:0] request vector, bit 0 has the highest priority
//     valid_o               at least one request bit is set
//     id_o    [ID_W-1:0]    index of the lowest set request bit (0 when none)
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter  int NUM_INT = 8,
  localparam int ID_W    = $clog2(NUM_INT)
) (
  input  logic [NUM_INT-1:0] req_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  // Scan from the top index downwards so that the last hit, which is the
  // lowest set index, is the one that sticks.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        id_o    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl
//   Interrupt controller: collects NUM_INT edge- or level-mode sources into a
//   PENDING register, masks them, and presents the lowest-index eligible
//   channel to the CPU through a request/acknowledge/end-of-interrupt handshake.
//   Ports:
//     clk, reset           clock and synchronous active-high reset
//     irq_in               interrupt sources (already synchronous to clk)
//     reg_addr/reg_d/reg_we register access: 0 PENDING (W1C), 1 MASK, 2 MODE,
//                          3 STATUS (read-only)
//     reg_q                registered read data, one cycle after reg_addr
//     cpu_int, cpu_int_id  request to the CPU and the latched channel id
//     cpu_ack, cpu_eoi     CPU acceptance and end-of-service pulses
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter  int NUM_INT = 8,
  localparam int ID_W    = $clog2(NUM_INT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_INT-1:0] irq_in,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_d,
  input  logic               reg_we,
  output logic [31:0]        reg_q,
  output logic               cpu_int,
  output logic [ID_W-1:0]    cpu_int_id,
  input  logic               cpu_ack,
  input  logic               cpu_eoi
);

  logic [NUM_INT-1:0] irqSync_q, irqHist_q;
  logic [NUM_INT-1:0] pending_q, pending_d;
  logic [NUM_INT-1:0] mask_q, mode_q;
  logic [NUM_INT-1:0] rise, eligible, latchedOneHot, ackClear, w1cClear;
  logic [ID_W-1:0]    intId_q, intId_d, encId;
  logic               encValid;
  ctrlState_e         state_q, state_d;
  logic [31:0]        regRead_q, regRead_d, statusWord;

  // Register bits beyond the implemented channels are intentionally dropped.
  if (NUM_INT < 32) begin : g_unusedData
    logic unusedRegD;
    assign unusedRegD = ^reg_d[31:NUM_INT];
  end

  assign rise          = irqSync_q & ~irqHist_q;
  assign eligible      = pending_q & mask_q;
  assign latchedOneHot = NUM_INT'(1) << intId_q;
  assign cpu_int       = (state_q == REQ);
  assign cpu_int_id    = intId_q;
  assign reg_q         = regRead_q;

  int_prio_enc #(
    .NUM_INT (NUM_INT)
  ) u_prioEnc (
    .req_i   (eligible),
    .valid_o (encValid),
    .id_o    (encId)
  );

  // Pending update. Edge channels latch a rise and are cleared by W1C or by
  // the CPU accepting that very channel; a simultaneous rise keeps the bit set.
  // Level channels simply follow the registered input and ignore both clears.
  always_comb begin
    ackClear  = '0;
    w1cClear  = '0;
    if (state_q == REQ && cpu_ack) begin
      ackClear = latchedOneHot;
    end
    if (reg_we && reg_addr == ADDR_PENDING) begin
      w1cClear = reg_d[NUM_INT-1:0];
    end
    pending_d = (mode_q & irqSync_q)
              | (~mode_q & (rise | (pending_q & ~(ackClear | w1cClear))));
  end

  // Arbitration FSM next state. The channel id is latched on entry to REQ and
  // held there, so a higher-priority arrival cannot preempt the request. An
  // acknowledge beats withdrawal when both happen in the same cycle.
  always_comb begin
    state_d = state_q;
    intId_d = intId_q;
    unique case (state_q)
      IDLE: begin
        if (encValid) begin
          state_d = REQ;
          intId_d = encId;
        end
      end
      REQ: begin
        if (cpu_ack) begin
          state_d = INSVC;
        end else if ((eligible & latchedOneHot) == '0) begin
          state_d = IDLE;
        end
      end
      INSVC: begin
        if (cpu_eoi) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read mux. STATUS packs the FSM state above the latched id; every other
  // bit reads as zero.
  always_comb begin
    statusWord = '0;
    statusWord[STATUS_STATE_LSB +: 2] = state_q;
    statusWord[ID_W-1:0]              = intId_q;
    regRead_d = '0;
    unique case (reg_addr)
      ADDR_PENDING: regRead_d = 32'(pending_q);
      ADDR_MASK:    regRead_d = 32'(mask_q);
      ADDR_MODE:    regRead_d = 32'(mode_q);
      ADDR_STATUS:  regRead_d = statusWord;
      default:      regRead_d = '0;
    endcase
  end

  // Input sampling, pending and read-data registers. A source held high
  // across reset release shows up as exactly one rise because both stages
  // restart from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      irqSync_q <= '0;
      irqHist_q <= '0;
      pending_q <= '0;
      regRead_q <= '0;
    end else begin
      irqSync_q <= irq_in;
      irqHist_q <= irqSync_q;
      pending_q <= pending_d;
      regRead_q <= regRead_d;
    end
  end

  // Software-written configuration; a write is visible from the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      mode_q <= '0;
    end else if (reg_we) begin
      if (reg_addr == ADDR_MASK) begin
        mask_q <= reg_d[NUM_INT-1:0];
      end
      if (reg_addr == ADDR_MODE) begin
        mode_q <= reg_d[NUM_INT-1:0];
      end
    end
  end

  // FSM state and latched id; reset abandons any request or service.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      intId_q <= '0;
    end else begin
      state_q <= state_d;
      intId_q <= intId_d;
    end
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter: NUM_INT, 8, number of interrupt channels (legal 2..32).
REQ-002 Derived constant: ID_W, clog2(NUM_INT), channel-id width (not overridable).
REQ-003 Port: clk  input  1  system clock, same domain as CPU and MemoryUnit.
REQ-004 Port: reset  input  1  reset, synchronous, active-high.
REQ-005 Port: irq_in  input  NUM_INT  interrupt sources, already stabilised to clk, active-high.
REQ-006 Port: reg_addr  input  2  register select (0 PENDING, 1 MASK, 2 MODE, 3 STATUS).
REQ-007 Port: reg_d  input  32  register write data.
REQ-008 Port: reg_we  input  1  register write strobe, one cycle.
REQ-009 Port: reg_q  output  32  register read data, registered.
REQ-010 Port: cpu_int  output  1  interrupt request to CPU.
REQ-011 Port: cpu_int_id  output  ID_W  id of requested channel.
REQ-012 Port: cpu_ack  input  1  CPU accepts request, one-cycle pulse.
REQ-013 Port: cpu_eoi  input  1  CPU end of interrupt service, one-cycle pulse.

Function
REQ-014 irq_in SHALL be registered into irq_s, then irq_s into irq_h; rise = irq_s AND NOT irq_h.
REQ-015 Edge-mode channel (MODE bit 0): PENDING bit set on rise; cleared by acceptance of that channel or by writing 1 to it at address 0 (W1C).
REQ-016 Level-mode channel (MODE bit 1): PENDING bit SHALL equal irq_s each cycle; W1C and acceptance have no effect.
REQ-017 Set and clear of the same PENDING bit in one cycle: set wins.
REQ-018 eligible = PENDING AND MASK; selected channel = lowest-index eligible bit (index 0 highest priority).
REQ-019 FSM states IDLE, REQ, INSVC; cpu_int = 1 only in REQ.
REQ-020 IDLE: eligible nonzero -> REQ, latch selected id into cpu_int_id.
REQ-021 REQ: cpu_ack -> INSVC, clear latched edge-mode PENDING bit; no re-arbitration while in REQ (no preemption).
REQ-022 REQ: latched channel no longer eligible (masked or W1C) and no cpu_ack -> IDLE (withdraw); cpu_ack wins over withdraw in the same cycle.
REQ-023 INSVC: cpu_eoi -> IDLE; new rises keep accumulating in PENDING.
REQ-024 cpu_ack outside REQ and cpu_eoi outside INSVC SHALL be ignored.
REQ-025 Latency: irq_in high sampled at edge k, channel unmasked, FSM IDLE -> PENDING set after edge k+1, cpu_int high after edge k+2.
REQ-026 Register reads: reg_q updated at each clk edge from reg_addr; one-cycle read latency; bits >= NUM_INT read 0.
REQ-027 MASK and MODE writes take effect the cycle after reg_we; bits >= NUM_INT ignored.
REQ-028 STATUS = {state[1:0] at bits 9:8, cpu_int_id at bits ID_W-1:0}, other bits 0; writes ignored.

Reset
REQ-029 On reset: PENDING, MASK, MODE, irq_s, irq_h = 0; FSM IDLE; cpu_int 0; cpu_int_id 0; reg_q 0.
REQ-030 Reset mid-request or mid-service SHALL abandon it; a line held high across reset release counts as one rise.

Structure
REQ-031 Package int_ctrl_pkg SHALL hold the FSM state type and register-address constants.
REQ-032 One sub-module int_prio_enc (parametrised NUM_INT lowest-index priority encoder, valid + id outputs).

Verification
REQ-033 NUM_INT=8, MASK=0xFF, edge pulse on irq_in[5] -> cpu_int high 2 cycles after sample, id=5; ack -> PENDING[5]=0; eoi -> IDLE.
REQ-034 Rises on channels 6 and 2 in the same cycle -> id=2 first; after ack+eoi, id=6 next.
REQ-035 In REQ for id=4, clear MASK[4] with no ack -> cpu_int drops next cycle, FSM IDLE, PENDING[4] still 1.
REQ-036 Level mode on channel 3, irq_in[3] held high -> after ack+eoi re-requests id=3; W1C of bit 3 has no effect.
REQ-037 W1C and rise on channel 1 in the same cycle -> PENDING[1]=1.
REQ-038 Assert reset while in INSVC -> next cycle all outputs 0, STATUS=0, MASK=0.
